// File: rtl/sl_preceptron_mem_arbiter.sv
// Session-based arbiter sharing the single-port weight SRAM between the host port and the MAC engine.
// Reads are tagged through an RD_LATENCY-deep pipeline, which also drains before every ownership change.
module sl_preceptron_mem_arbiter #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int RD_LATENCY    = 1,
  parameter int HOST_MAX_WAIT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  session_start,
  input  logic                  session_done,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  input  logic                  eng_req,
  input  logic                  eng_we,
  input  logic [ADDR_WIDTH-1:0] eng_addr,
  input  logic [DATA_WIDTH-1:0] eng_wdata,
  output logic                  eng_stall,
  output logic                  eng_rvalid,
  output logic [DATA_WIDTH-1:0] eng_rdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  session_active,
  output logic                  proto_err
);

  localparam int WAIT_W = (HOST_MAX_WAIT > 0) ? $clog2(HOST_MAX_WAIT + 1) : 1;

  typedef enum logic [1:0] {
    HOST_OWN      = 2'd0,
    DRAIN_TO_ENG  = 2'd1,
    ENG_OWN       = 2'd2,
    DRAIN_TO_HOST = 2'd3
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [RD_LATENCY-1:0]   pipe_vld_r, pipe_tag_r;
  logic [RD_LATENCY-1:0]   pipe_vld_nxt_s, pipe_tag_nxt_s;
  logic [WAIT_W-1:0]       wait_cnt_r, wait_cnt_nxt_s;
  logic                    proto_err_r, err_set_s;
  logic                    host_gnt_s, eng_gnt_s, steal_s, rd_issue_s, pipe_empty_nxt_s;

  assign steal_s = (HOST_MAX_WAIT != 0) && host_req && (wait_cnt_r == WAIT_W'(HOST_MAX_WAIT));

  // Grant selection; everything is held off while reset is asserted
  always_comb begin
    host_gnt_s = 1'b0;
    eng_gnt_s  = 1'b0;
    if (!rst_n) begin
      host_gnt_s = 1'b0;
    end else begin
      case (state_r)
        HOST_OWN: host_gnt_s = host_req;
        ENG_OWN: begin
          if (steal_s) begin
            host_gnt_s = 1'b1;
          end else begin
            eng_gnt_s = eng_req;
          end
        end
        default: host_gnt_s = 1'b0;
      endcase
    end
  end

  assign rd_issue_s = (host_gnt_s && !host_we) || (eng_gnt_s && !eng_we);

  // Read-tag shift register: stage 0 takes the new read, the last stage is the returning one
  always_comb begin
    pipe_vld_nxt_s    = '0;
    pipe_tag_nxt_s    = '0;
    pipe_vld_nxt_s[0] = rd_issue_s;
    pipe_tag_nxt_s[0] = eng_gnt_s;
    for (int k = 1; k < RD_LATENCY; k++) begin
      pipe_vld_nxt_s[k] = pipe_vld_r[k-1];
      pipe_tag_nxt_s[k] = pipe_tag_r[k-1];
    end
    pipe_empty_nxt_s = (pipe_vld_nxt_s == '0);
  end

  // Session FSM next state and protocol-error detection
  always_comb begin
    state_nxt_s = state_r;
    err_set_s   = 1'b0;
    if (!rst_n) begin
      state_nxt_s = HOST_OWN;
    end else begin
      case (state_r)
        HOST_OWN: begin
          if (session_start) begin
            state_nxt_s = pipe_empty_nxt_s ? ENG_OWN : DRAIN_TO_ENG;
          end else begin
            state_nxt_s = HOST_OWN;
          end
          err_set_s = session_done;
        end
        DRAIN_TO_ENG: begin
          if (pipe_empty_nxt_s) begin
            state_nxt_s = ENG_OWN;
          end else begin
            state_nxt_s = DRAIN_TO_ENG;
          end
          err_set_s = session_start;
        end
        ENG_OWN: begin
          if (session_done) begin
            state_nxt_s = DRAIN_TO_HOST;
          end else begin
            state_nxt_s = ENG_OWN;
          end
          err_set_s = session_start;
        end
        DRAIN_TO_HOST: begin
          if (pipe_empty_nxt_s) begin
            state_nxt_s = HOST_OWN;
          end else begin
            state_nxt_s = DRAIN_TO_HOST;
          end
          err_set_s = session_start;
        end
        default: state_nxt_s = HOST_OWN;
      endcase
    end
  end

  // Host starvation counter, only live while the engine owns the SRAM
  always_comb begin
    wait_cnt_nxt_s = '0;
    if ((HOST_MAX_WAIT != 0) && (state_r == ENG_OWN) && (state_nxt_s == ENG_OWN) &&
        host_req && !host_gnt_s) begin
      wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_nxt_s = '0;
    end
  end

  // State, pipeline, counter and sticky error registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= HOST_OWN;
      pipe_vld_r  <= '0;
      pipe_tag_r  <= '0;
      wait_cnt_r  <= '0;
      proto_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pipe_vld_r  <= pipe_vld_nxt_s;
      pipe_tag_r  <= pipe_tag_nxt_s;
      wait_cnt_r  <= wait_cnt_nxt_s;
      proto_err_r <= proto_err_r | err_set_s;
    end
  end

  // SRAM control mux from whichever requester holds the grant
  always_comb begin
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (host_gnt_s) begin
      mem_wen   = host_we;
      mem_ren   = !host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (eng_gnt_s) begin
      mem_wen   = eng_we;
      mem_ren   = !eng_we;
      mem_addr  = eng_addr;
      mem_wdata = eng_wdata;
    end else begin
      mem_wen   = 1'b0;
    end
  end

  assign host_gnt       = host_gnt_s;
  assign eng_stall      = eng_req && !eng_gnt_s;
  assign host_rvalid    = rst_n && pipe_vld_r[RD_LATENCY-1] && !pipe_tag_r[RD_LATENCY-1];
  assign eng_rvalid     = rst_n && pipe_vld_r[RD_LATENCY-1] && pipe_tag_r[RD_LATENCY-1];
  assign host_rdata     = host_rvalid ? mem_rdata : '0;
  assign eng_rdata      = eng_rvalid ? mem_rdata : '0;
  assign session_active = rst_n && ((state_r == ENG_OWN) || (state_r == DRAIN_TO_HOST));
  assign proto_err      = rst_n && proto_err_r;

endmodule

// File: tb/tb_sl_preceptron_mem_arbiter.sv
// Directed bench: instance A (RD_LATENCY=1, HOST_MAX_WAIT=4) and instance B (RD_LATENCY=3, HOST_MAX_WAIT=0)
// share one stimulus set; each has its own behavioural SRAM.
module tb_sl_preceptron_mem_arbiter;

  logic        clk, rst_n, session_start, session_done;
  logic        host_req, host_we, eng_req, eng_we;
  logic [15:0] host_addr, eng_addr;
  logic [7:0]  host_wdata, eng_wdata;

  logic        a_host_gnt, a_host_rvalid, a_eng_stall, a_eng_rvalid, a_mem_wen, a_mem_ren;
  logic        a_session_active, a_proto_err;
  logic [7:0]  a_host_rdata, a_eng_rdata, a_mem_wdata, a_mem_rdata;
  logic [15:0] a_mem_addr;
  logic        b_host_gnt, b_host_rvalid, b_eng_stall, b_eng_rvalid, b_mem_wen, b_mem_ren;
  logic        b_session_active, b_proto_err;
  logic [7:0]  b_host_rdata, b_eng_rdata, b_mem_wdata, b_mem_rdata;
  logic [15:0] b_mem_addr;

  logic [7:0]  mem_a [256];
  logic [7:0]  mem_b [256];
  logic [7:0]  a_q, b_q0, b_q1, b_q2;

  int checks   = 0;
  int failures = 0;

  sl_preceptron_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .RD_LATENCY(1), .HOST_MAX_WAIT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .session_start(session_start), .session_done(session_done),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(a_host_gnt), .host_rvalid(a_host_rvalid), .host_rdata(a_host_rdata),
    .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_stall(a_eng_stall), .eng_rvalid(a_eng_rvalid), .eng_rdata(a_eng_rdata),
    .mem_wen(a_mem_wen), .mem_ren(a_mem_ren), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .session_active(a_session_active), .proto_err(a_proto_err)
  );

  sl_preceptron_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .RD_LATENCY(3), .HOST_MAX_WAIT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .session_start(session_start), .session_done(session_done),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(b_host_gnt), .host_rvalid(b_host_rvalid), .host_rdata(b_host_rdata),
    .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_stall(b_eng_stall), .eng_rvalid(b_eng_rvalid), .eng_rdata(b_eng_rdata),
    .mem_wen(b_mem_wen), .mem_ren(b_mem_ren), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .session_active(b_session_active), .proto_err(b_proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model, latency 1
  always @(posedge clk) begin
    if (a_mem_wen) mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
    a_q <= a_mem_ren ? mem_a[a_mem_addr[7:0]] : 8'h00;
  end
  assign a_mem_rdata = a_q;

  // SRAM model, latency 3
  always @(posedge clk) begin
    if (b_mem_wen) mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
    b_q0 <= b_mem_ren ? mem_b[b_mem_addr[7:0]] : 8'h00;
    b_q1 <= b_q0;
    b_q2 <= b_q1;
  end
  assign b_mem_rdata = b_q2;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    session_start = 1'b0; session_done = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 16'h0000; host_wdata = 8'h00;
    eng_req = 1'b0; eng_we = 1'b0; eng_addr = 16'h0000; eng_wdata = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [47:0] exp_v;
    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    eng_req = 1'b1;
    #4;
    exp_v = {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
    checks++;
    if ({a_host_gnt, a_host_rvalid, a_host_rdata, a_eng_stall, a_eng_rvalid, a_eng_rdata, a_mem_wen,
         a_mem_ren, a_mem_addr, a_mem_wdata, a_session_active, a_proto_err} !== exp_v) begin
      failures++;
      $display("FAIL reset_outputs_a: got %h expected %h", {a_host_gnt, a_host_rvalid, a_host_rdata,
               a_eng_stall, a_eng_rvalid, a_eng_rdata, a_mem_wen, a_mem_ren, a_mem_addr, a_mem_wdata,
               a_session_active, a_proto_err}, exp_v);
    end
    checks++;
    if ({b_host_gnt, b_host_rvalid, b_host_rdata, b_eng_stall, b_eng_rvalid, b_eng_rdata, b_mem_wen,
         b_mem_ren, b_mem_addr, b_mem_wdata, b_session_active, b_proto_err} !== exp_v) begin
      failures++;
      $display("FAIL reset_outputs_b: got %h expected %h", {b_host_gnt, b_host_rvalid, b_host_rdata,
               b_eng_stall, b_eng_rvalid, b_eng_rdata, b_mem_wen, b_mem_ren, b_mem_addr, b_mem_wdata,
               b_session_active, b_proto_err}, exp_v);
    end
    rst_n = 1'b1;
    eng_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_host_wr_rd();
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0010; host_wdata = 8'hA5;
    #4;
    checks++;
    if ({a_host_gnt, a_mem_wen, a_mem_ren, a_mem_addr, a_mem_wdata} !== {1'b1, 1'b1, 1'b0, 16'h0010, 8'hA5}) begin
      failures++;
      $display("FAIL host_write: got %h expected %h", {a_host_gnt, a_mem_wen, a_mem_ren, a_mem_addr, a_mem_wdata},
               {1'b1, 1'b1, 1'b0, 16'h0010, 8'hA5});
    end
    next_cycle();
    host_we = 1'b0;
    #4;
    checks++;
    if ({a_host_gnt, a_mem_wen, a_mem_ren, a_mem_addr} !== {1'b1, 1'b0, 1'b1, 16'h0010}) begin
      failures++;
      $display("FAIL host_read_issue: got %h expected %h", {a_host_gnt, a_mem_wen, a_mem_ren, a_mem_addr},
               {1'b1, 1'b0, 1'b1, 16'h0010});
    end
    next_cycle();
    host_req = 1'b0;
    #4;
    checks++;
    if ({a_host_rvalid, a_host_rdata, a_eng_rvalid, a_eng_rdata} !== {1'b1, 8'hA5, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL host_read_return: got %h expected %h", {a_host_rvalid, a_host_rdata, a_eng_rvalid, a_eng_rdata},
               {1'b1, 8'hA5, 1'b0, 8'h00});
    end
    next_cycle();
  endtask

  task automatic test_handoff();
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0020; host_wdata = 8'h3C;
    next_cycle();
    host_we = 1'b0; host_addr = 16'h0010; session_start = 1'b1;
    eng_req = 1'b1; eng_we = 1'b0; eng_addr = 16'h0020;
    #4;
    checks++;
    if ({a_host_gnt, a_eng_stall, a_session_active} !== 3'b110) begin
      failures++;
      $display("FAIL handoff_T: got %b expected %b", {a_host_gnt, a_eng_stall, a_session_active}, 3'b110);
    end
    next_cycle();
    session_start = 1'b0; host_req = 1'b0;
    #4;
    checks++;
    if ({a_host_rvalid, a_host_rdata, a_eng_stall, a_mem_ren, a_session_active} !== {1'b1, 8'hA5, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL handoff_drain: got %h expected %h", {a_host_rvalid, a_host_rdata, a_eng_stall, a_mem_ren,
               a_session_active}, {1'b1, 8'hA5, 1'b1, 1'b0, 1'b0});
    end
    next_cycle();
    #4;
    checks++;
    if ({a_eng_stall, a_mem_ren, a_mem_addr, a_session_active} !== {1'b0, 1'b1, 16'h0020, 1'b1}) begin
      failures++;
      $display("FAIL handoff_eng_own: got %h expected %h", {a_eng_stall, a_mem_ren, a_mem_addr, a_session_active},
               {1'b0, 1'b1, 16'h0020, 1'b1});
    end
    next_cycle();
    eng_req = 1'b0;
    #4;
    checks++;
    if ({a_eng_rvalid, a_eng_rdata, a_host_rvalid, a_host_rdata} !== {1'b1, 8'h3C, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL handoff_eng_return: got %h expected %h", {a_eng_rvalid, a_eng_rdata, a_host_rvalid, a_host_rdata},
               {1'b1, 8'h3C, 1'b0, 8'h00});
    end
    next_cycle();
  endtask

  task automatic test_steal();
    int gcnt = 0;
    int gidx = -1;
    bit drained = 1'b0;
    for (int i = 0; i < 10; i++) begin
      host_req = (gcnt == 0); host_we = 1'b0; host_addr = 16'h0010;
      eng_req = 1'b1; eng_we = 1'b0; eng_addr = 16'h0020;
      #4;
      if (gidx >= 0 && i == gidx + 1) begin
        checks++;
        if ({a_host_rvalid, a_host_rdata} !== {1'b1, 8'hA5}) begin
          failures++;
          $display("FAIL steal_host_return: got %h expected %h", {a_host_rvalid, a_host_rdata}, {1'b1, 8'hA5});
        end
      end
      checks++;
      if ({a_host_gnt, a_eng_stall} !== {(i == 4), (i == 4)}) begin
        failures++;
        $display("FAIL steal_cycle%0d: gnt/stall got %b expected %b", i, {a_host_gnt, a_eng_stall},
                 {(i == 4), (i == 4)});
      end
      if (a_host_gnt) begin
        gcnt++;
        gidx = i;
      end
      next_cycle();
    end
    checks++;
    if (gcnt != 1) begin
      failures++;
      $display("FAIL steal_count: got %0d expected 1", gcnt);
    end
    host_req = 1'b0; eng_req = 1'b0; session_done = 1'b1;
    next_cycle();
    session_done = 1'b0;
    for (int i = 0; i < 6 && !drained; i++) begin
      #4;
      if (!a_session_active) drained = 1'b1;
      next_cycle();
    end
    checks++;
    if (!drained) begin
      failures++;
      $display("FAIL steal_session_end: session_active got 1 expected 0 within 6 cycles");
    end
  endtask

  task automatic test_no_steal();
    int gcnt = 0;
    do_reset();
    session_start = 1'b1;
    next_cycle();
    session_start = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010;
    eng_req = 1'b1; eng_we = 1'b0; eng_addr = 16'h0020;
    for (int i = 0; i < 12; i++) begin
      #4;
      if (b_host_gnt || b_eng_stall) gcnt++;
      next_cycle();
    end
    checks++;
    if (gcnt != 0) begin
      failures++;
      $display("FAIL no_steal_window: host_gnt/eng_stall cycles got %0d expected 0", gcnt);
    end
    session_done = 1'b1;
    next_cycle();
    session_done = 1'b0; eng_req = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #4;
      checks++;
      if (b_host_gnt !== (j == 3)) begin
        failures++;
        $display("FAIL no_steal_drain%0d: host_gnt got %b expected %b", j, b_host_gnt, (j == 3));
      end
      next_cycle();
    end
    host_req = 1'b0;
  endtask

  task automatic test_proto_err();
    do_reset();
    session_done = 1'b1;
    #4;
    checks++;
    if (a_proto_err !== 1'b0) begin
      failures++;
      $display("FAIL proto_err_early: got %b expected 0", a_proto_err);
    end
    next_cycle();
    session_done = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010;
    #4;
    checks++;
    if ({a_proto_err, a_session_active, a_host_gnt} !== 3'b101) begin
      failures++;
      $display("FAIL proto_err_set: got %b expected %b", {a_proto_err, a_session_active, a_host_gnt}, 3'b101);
    end
    next_cycle();
    host_req = 1'b0; session_start = 1'b1;
    next_cycle();
    session_start = 1'b0; eng_req = 1'b1; eng_we = 1'b1; eng_addr = 16'h0030; eng_wdata = 8'h11;
    #4;
    checks++;
    if ({a_proto_err, a_session_active, a_eng_stall, a_mem_wen} !== 4'b1101) begin
      failures++;
      $display("FAIL proto_err_sticky: got %b expected %b", {a_proto_err, a_session_active, a_eng_stall, a_mem_wen},
               4'b1101);
    end
    next_cycle();
    eng_req = 1'b0; session_done = 1'b1;
    next_cycle();
    session_done = 1'b0;
    repeat (3) next_cycle();
  endtask

  task automatic test_reset_inflight();
    int rv = 0;
    logic [47:0] exp_v;
    do_reset();
    session_start = 1'b1;
    next_cycle();
    session_start = 1'b0; eng_req = 1'b1; eng_we = 1'b0; eng_addr = 16'h0020;
    #4;
    checks++;
    if ({b_eng_stall, b_mem_ren} !== 2'b01) begin
      failures++;
      $display("FAIL inflight_issue: got %b expected %b", {b_eng_stall, b_mem_ren}, 2'b01);
    end
    next_cycle();
    rst_n = 1'b0;
    #4;
    exp_v = {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
    checks++;
    if ({b_host_gnt, b_host_rvalid, b_host_rdata, b_eng_stall, b_eng_rvalid, b_eng_rdata, b_mem_wen,
         b_mem_ren, b_mem_addr, b_mem_wdata, b_session_active, b_proto_err} !== exp_v) begin
      failures++;
      $display("FAIL inflight_reset_outputs: got %h expected %h", {b_host_gnt, b_host_rvalid, b_host_rdata,
               b_eng_stall, b_eng_rvalid, b_eng_rdata, b_mem_wen, b_mem_ren, b_mem_addr, b_mem_wdata,
               b_session_active, b_proto_err}, exp_v);
    end
    next_cycle();
    rst_n = 1'b1; eng_req = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010;
    #4;
    checks++;
    if ({b_host_gnt, b_session_active, b_eng_rvalid} !== 3'b100) begin
      failures++;
      $display("FAIL inflight_host_own: got %b expected %b", {b_host_gnt, b_session_active, b_eng_rvalid}, 3'b100);
    end
    next_cycle();
    host_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #4;
      if (b_eng_rvalid) rv++;
      next_cycle();
    end
    checks++;
    if (rv != 0) begin
      failures++;
      $display("FAIL inflight_discarded: eng_rvalid cycles got %0d expected 0", rv);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    test_reset();
    test_host_wr_rd();
    test_handoff();
    test_steal();
    test_no_steal();
    test_proto_err();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
